// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the EX-stage HI/LO unit: funct codes, FSM states, op decode.
package mips_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } md_kind_e;

  typedef struct packed {
    md_kind_e kind;
    logic     sgn;
  } md_op_t;

  // True for the four iterative multiply/divide functs
  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) || (f == FUNCT_DIV) || (f == FUNCT_DIVU);
  endfunction

  // True for any instruction this unit acts on
  function automatic logic is_hilo(input logic [5:0] f);
    return is_muldiv(f) || (f == FUNCT_MFHI) || (f == FUNCT_MTHI) ||
           (f == FUNCT_MFLO) || (f == FUNCT_MTLO);
  endfunction

  // funct[1] selects divide, funct[0] clear means signed
  function automatic md_op_t decode_op(input logic [5:0] f);
    md_op_t op;
    op.kind = f[1] ? OP_DIV : OP_MUL;
    op.sgn  = ~f[0];
    return op;
  endfunction

endpackage

// File: rtl/muldiv_shift_core.sv
// One-bit-per-step unsigned shift-add multiplier / restoring divider datapath.
module muldiv_shift_core
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               load_i,
  input  logic               step_i,
  input  md_kind_e           kind_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  md_kind_e           kind_q, kind_d;

  logic [WIDTH:0]     sum_c;
  logic [WIDTH:0]     rem_sh_c;
  logic [WIDTH:0]     diff_c;

  // Single iteration: add-and-shift-right for multiply, shift-left-and-trial-subtract for divide
  always_comb begin
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    kind_d   = kind_q;
    sum_c    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    rem_sh_c = acc_q[2*WIDTH-1:WIDTH-1];
    diff_c   = rem_sh_c - {1'b0, opnd_q};
    if (load_i) begin
      kind_d = kind_i;
      // Divide keeps the dividend in the low half; multiply keeps the multiplier there
      acc_d  = {WIDTH'(0), (kind_i == OP_DIV) ? a_i : b_i};
      opnd_d = (kind_i == OP_DIV) ? b_i : a_i;
    end else if (step_i) begin
      if (kind_q == OP_MUL) begin
        acc_d = acc_q[0] ? {sum_c, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
      end else if (!diff_c[WIDTH]) begin
        acc_d = {diff_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {rem_sh_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Accumulator / operand registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      kind_q <= OP_MUL;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      kind_q <= kind_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage HI/LO unit: iterative MULT/DIV sequencing, sign fix-up, HI/LO registers and stall.
module ex_muldiv_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_valid,
  input  logic             i_flush,
  input  logic [5:0]       i_funct,
  input  logic [WIDTH-1:0] i_rs_data,
  input  logic [WIDTH-1:0] i_rt_data,
  output logic             o_stall,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_mf_data,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   rs_raw_q, rs_raw_d;
  md_kind_e           kind_q, kind_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;

  logic               hit_c;
  logic               idle_c;
  logic               start_c;
  logic               step_c;
  logic               fix_c;
  md_op_t             op_c;
  logic [WIDTH-1:0]   rs_abs_c, rt_abs_c;
  logic [2*WIDTH-1:0] acc_c;
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0]   res_hi_c, res_lo_c;

  assign hit_c  = i_valid & ~i_flush & is_hilo(i_funct);
  assign idle_c = (state_q == IDLE);
  assign op_c   = decode_op(i_funct);

  // Magnitudes for signed ops; the core always works unsigned
  assign rs_abs_c = (op_c.sgn && i_rs_data[WIDTH-1]) ? WIDTH'(0) - i_rs_data : i_rs_data;
  assign rt_abs_c = (op_c.sgn && i_rt_data[WIDTH-1]) ? WIDTH'(0) - i_rt_data : i_rt_data;

  muldiv_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .nrst   (nrst),
    .load_i (start_c),
    .step_i (step_c),
    .kind_i (op_c.kind),
    .a_i    (rs_abs_c),
    .b_i    (rt_abs_c),
    .acc_o  (acc_c)
  );

  // FSM state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (hit_c && is_muldiv(i_funct)) state_d = RUN;
      RUN:  if (cnt_q == CW'(WIDTH - 1))     state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: control strobes, busy/stall, move-from data
  always_comb begin
    start_c   = 1'b0;
    step_c    = 1'b0;
    fix_c     = 1'b0;
    o_busy    = ~idle_c;
    o_stall   = ~idle_c & hit_c;
    o_mf_data = '0;
    case (state_q)
      IDLE: begin
        start_c = hit_c & is_muldiv(i_funct);
        if (hit_c && i_funct == FUNCT_MFHI) o_mf_data = hi_q;
        if (hit_c && i_funct == FUNCT_MFLO) o_mf_data = lo_q;
      end
      RUN:     step_c = 1'b1;
      FIX:     fix_c  = 1'b1;
      default: ;
    endcase
  end

  // Final sign correction; divide-by-zero bypasses it with fixed results
  always_comb begin
    prod_c   = neg_res_q ? (2*WIDTH)'(0) - acc_c : acc_c;
    res_hi_c = prod_c[2*WIDTH-1:WIDTH];
    res_lo_c = prod_c[WIDTH-1:0];
    if (kind_q == OP_DIV) begin
      if (dz_q) begin
        res_lo_c = '1;
        res_hi_c = rs_raw_q;
      end else begin
        res_lo_c = neg_res_q ? WIDTH'(0) - acc_c[WIDTH-1:0] : acc_c[WIDTH-1:0];
        res_hi_c = neg_rem_q ? WIDTH'(0) - acc_c[2*WIDTH-1:WIDTH] : acc_c[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Next values for counter, latched op attributes and HI/LO
  always_comb begin
    cnt_d     = cnt_q;
    kind_d    = kind_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    rs_raw_d  = rs_raw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (start_c) begin
      cnt_d     = '0;
      kind_d    = op_c.kind;
      neg_res_d = op_c.sgn & (i_rs_data[WIDTH-1] ^ i_rt_data[WIDTH-1]);
      neg_rem_d = op_c.sgn & i_rs_data[WIDTH-1];
      dz_d      = (op_c.kind == OP_DIV) && (i_rt_data == '0);
      rs_raw_d  = i_rs_data;
    end else if (step_c) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (fix_c) begin
      hi_d = res_hi_c;
      lo_d = res_lo_c;
    end else if (idle_c && hit_c && i_funct == FUNCT_MTHI) begin
      hi_d = i_rs_data;
    end else if (idle_c && hit_c && i_funct == FUNCT_MTLO) begin
      lo_d = i_rs_data;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q     <= '0;
      kind_q    <= OP_MUL;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      rs_raw_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      kind_q    <= kind_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      rs_raw_q  <= rs_raw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign o_hi = hi_q;
  assign o_lo = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit with hand-computed HI/LO results.
module tb_ex_muldiv_unit;

  localparam int unsigned W = 32;

  logic          clk;
  logic          nrst;
  logic          i_valid;
  logic          i_flush;
  logic [5:0]    i_funct;
  logic [W-1:0]  i_rs_data;
  logic [W-1:0]  i_rt_data;
  logic          o_stall;
  logic          o_busy;
  logic [W-1:0]  o_mf_data;
  logic [W-1:0]  o_hi;
  logic [W-1:0]  o_lo;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .i_valid   (i_valid),
    .i_flush   (i_flush),
    .i_funct   (i_funct),
    .i_rs_data (i_rs_data),
    .i_rt_data (i_rt_data),
    .o_stall   (o_stall),
    .o_busy    (o_busy),
    .o_mf_data (o_mf_data),
    .o_hi      (o_hi),
    .o_lo      (o_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] f, input logic [W-1:0] rs,
                       input logic [W-1:0] rt, input logic fl);
    i_valid   = v;
    i_funct   = f;
    i_rs_data = rs;
    i_rt_data = rt;
    i_flush   = fl;
  endtask

  // Issue one mul/div, scramble operands after start, count busy cycles; ends at posedge+1
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] rs, input logic [W-1:0] rt,
                        output int busy_cycles);
    drive(1'b1, f, rs, rt, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, F_ADD, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
    busy_cycles = 0;
    @(negedge clk);
    while (o_busy && busy_cycles < 200) begin
      busy_cycles++;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    nrst = 1'b0;
    drive(1'b0, F_ADD, '0, '0, 1'b0);
    #3;
    chk("rst_hi", o_hi, 32'h0);
    chk("rst_lo", o_lo, 32'h0);
    chk("rst_busy", W'(o_busy), 32'h0);
    chk("rst_stall", W'(o_stall), 32'h0);
    chk("rst_mf", o_mf_data, 32'h0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;

    // Unsigned max product and latency
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    chk("multu_busy_cycles", W'(cyc), 32'd33);
    chk("multu_hi", o_hi, 32'hFFFF_FFFE);
    chk("multu_lo", o_lo, 32'h0000_0001);

    run_op(F_MULT, 32'hFFFF_FFFD, 32'h0000_0007, cyc);
    chk("mult_neg_hi", o_hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", o_lo, 32'hFFFF_FFEB);

    run_op(F_MULT, 32'h8000_0000, 32'h8000_0000, cyc);
    chk("mult_min_hi", o_hi, 32'h4000_0000);
    chk("mult_min_lo", o_lo, 32'h0);

    run_op(F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, cyc);
    chk("div_busy_cycles", W'(cyc), 32'd33);
    chk("div_neg_lo", o_lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", o_hi, 32'hFFFF_FFFF);

    run_op(F_DIVU, 32'd100, 32'd0, cyc);
    chk("divu_zero_busy", W'(cyc), 32'd33);
    chk("divu_zero_lo", o_lo, 32'hFFFF_FFFF);
    chk("divu_zero_hi", o_hi, 32'h0000_0064);

    run_op(F_DIV, 32'hFFFF_FFF0, 32'd0, cyc);
    chk("div_zero_lo", o_lo, 32'hFFFF_FFFF);
    chk("div_zero_hi", o_hi, 32'hFFFF_FFF0);

    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    chk("div_ovf_lo", o_lo, 32'h8000_0000);
    chk("div_ovf_hi", o_hi, 32'h0);

    run_op(F_DIVU, 32'd100, 32'd7, cyc);
    chk("divu_lo", o_lo, 32'd14);
    chk("divu_hi", o_hi, 32'd2);

    // MFLO right behind MULTU stalls until the result is written
    drive(1'b1, F_MULTU, 32'd6, 32'd7, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, F_MFLO, 32'h0, 32'h0, 1'b0);
    cyc = 0;
    @(negedge clk);
    chk("mf_stalled_data", o_mf_data, 32'h0);
    while (o_stall && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    chk("mflo_stall_cycles", W'(cyc), 32'd33);
    chk("mflo_after_stall", o_mf_data, 32'h0000_002A);
    @(posedge clk); #1;
    drive(1'b0, F_ADD, '0, '0, 1'b0);

    // Non-HI/LO instruction passes while busy; an MT while busy stalls
    drive(1'b1, F_DIVU, 32'd50, 32'd5, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, F_ADD, 32'h1, 32'h2, 1'b0);
    @(negedge clk);
    chk("add_busy", W'(o_busy), 32'h1);
    chk("add_no_stall", W'(o_stall), 32'h0);
    @(posedge clk); #1;
    drive(1'b1, F_MTHI, 32'hAAAA, 32'h0, 1'b0);
    @(negedge clk);
    chk("mt_busy_stall", W'(o_stall), 32'h1);
    @(posedge clk); #1;
    drive(1'b0, F_ADD, '0, '0, 1'b0);
    cyc = 0;
    while (o_busy && cyc < 200) begin
      cyc++;
      @(posedge clk); #1;
    end
    chk("divu_50_5_lo", o_lo, 32'd10);
    chk("divu_50_5_hi", o_hi, 32'd0);

    // MTHI then MFHI
    drive(1'b1, F_MTHI, 32'h0000_1234, 32'h0, 1'b0);
    @(negedge clk);
    chk("mthi_no_stall", W'(o_stall), 32'h0);
    @(posedge clk); #1;
    drive(1'b1, F_MFHI, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("mfhi_after_mthi", o_mf_data, 32'h0000_1234);
    @(posedge clk); #1;

    // MTLO write lands at the edge: LO still old during the MT cycle
    drive(1'b1, F_MTLO, 32'h0000_0077, 32'h0, 1'b0);
    @(negedge clk);
    chk("mtlo_before_edge", o_lo, 32'd10);
    @(posedge clk); #1;
    chk("mtlo_after_edge", o_lo, 32'h0000_0077);

    // Flushed MTLO and flushed MFLO have no effect
    drive(1'b1, F_MTLO, 32'h0000_0055, 32'h0, 1'b1);
    @(posedge clk); #1;
    chk("mtlo_flushed", o_lo, 32'h0000_0077);
    drive(1'b1, F_MFLO, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("mflo_flushed", o_mf_data, 32'h0);
    @(posedge clk); #1;

    // Flushed MULTU does not start
    drive(1'b1, F_MULTU, 32'd3, 32'd3, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, F_ADD, '0, '0, 1'b0);
    chk("flush_no_start", W'(o_busy), 32'h0);

    // Reset mid-divide aborts immediately
    drive(1'b1, F_DIVU, 32'd1000, 32'd3, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, F_ADD, '0, '0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    nrst = 1'b0;
    #1;
    chk("abort_busy", W'(o_busy), 32'h0);
    chk("abort_hi", o_hi, 32'h0);
    chk("abort_lo", o_lo, 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;

    run_op(F_MULTU, 32'd2, 32'd3, cyc);
    chk("post_reset_cycles", W'(cyc), 32'd33);
    chk("post_reset_lo", o_lo, 32'd6);
    chk("post_reset_hi", o_hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
